// File: rtl/counter_updown_mod.sv
// counter_updown_mod
// Parametrised up/down modulo counter with synchronous clear, clamped
// parallel load, wrap-or-saturate behaviour at the range ends and
// registered event flags.
//
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   clear       synchronous clear (highest priority)
//   load        synchronous load of load_val (clamped to MAX_VAL)
//   load_val    load value
//   count_en    count enable
//   up_dn       1 = count up, 0 = count down
//   q_out       registered count, range 0..MAX_VAL
//   wrap        one-cycle pulse: count wrapped (SATURATE = 0)
//   sat_hit     one-cycle pulse: count held at a range end (SATURATE = 1)
//   ovf_sticky  set by any wrap/sat_hit event, cleared by clear or reset
//   at_max      q_out == MAX_VAL (decoded from the register only)
//   at_zero     q_out == 0       (decoded from the register only)

module counter_updown_mod #(
    parameter int               WIDTH    = 8,
    parameter longint unsigned  MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter int               SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             count_en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] q_out,
    output logic             wrap,
    output logic             sat_hit,
    output logic             ovf_sticky,
    output logic             at_max,
    output logic             at_zero
);

    generate
        if (WIDTH < 2 || WIDTH > 63) begin : g_bad_width
            $error("counter_updown_mod: WIDTH must be in 2..63");
        end
        if (MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
            $error("counter_updown_mod: MAX_VAL does not fit in WIDTH bits");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_W = MAX_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] load_clamped;

    always_comb begin
        load_clamped = (load_val > MAX_W) ? MAX_W : load_val;
    end

    // Range ends are detected by equality before stepping, so the
    // counter never relies on natural 2**WIDTH rollover.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_out      <= '0;
            wrap       <= 1'b0;
            sat_hit    <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            wrap    <= 1'b0;
            sat_hit <= 1'b0;
            if (clear) begin
                q_out      <= '0;
                ovf_sticky <= 1'b0;
            end else if (load) begin
                q_out <= load_clamped;
            end else if (count_en) begin
                if (up_dn) begin
                    if (q_out != MAX_W) begin
                        q_out <= q_out + ONE;
                    end else if (SATURATE != 0) begin
                        sat_hit    <= 1'b1;
                        ovf_sticky <= 1'b1;
                    end else begin
                        q_out      <= '0;
                        wrap       <= 1'b1;
                        ovf_sticky <= 1'b1;
                    end
                end else begin
                    if (q_out != '0) begin
                        q_out <= q_out - ONE;
                    end else if (SATURATE != 0) begin
                        sat_hit    <= 1'b1;
                        ovf_sticky <= 1'b1;
                    end else begin
                        q_out      <= MAX_W;
                        wrap       <= 1'b1;
                        ovf_sticky <= 1'b1;
                    end
                end
            end
        end
    end

    assign at_max  = (q_out == MAX_W);
    assign at_zero = (q_out == '0);

endmodule

// File: doc/counter_updown_mod.md
Name: counter_updown_mod

Overview:
- Parametrised up/down modulo counter: the next-generation general-purpose counter for the design library.
- Adds the following over the fixed 4-bit up-counter:
  - configurable width and terminal value;
  - direction control;
  - synchronous clear and parallel load;
  - wrap or saturate mode;
  - registered event flags.
- Used as the timebase/event counter inside control FSMs and as a standalone tick divider.

Parameters:
- WIDTH, 8, counter width in bits (WIDTH >= 2).
- MAX_VAL, 2**WIDTH-1, terminal value; count range is 0..MAX_VAL inclusive. Must be <= 2**WIDTH-1. Elaboration error otherwise.
- SATURATE, 0, 0 = wrap at range ends, 1 = hold at range ends.

Ports:
- clk  input  1  Single clock; all state updates on rising edge.
- reset_n  input  1  Asynchronous, active-low reset.
- clear  input  1  Synchronous clear to 0; highest-priority command.
- load  input  1  Synchronous parallel load of load_val.
- load_val  input  WIDTH  Load value; clamped to MAX_VAL.
- count_en  input  1  Count enable.
- up_dn  input  1  Direction: 1 = up, 0 = down.
- q_out  output  WIDTH  Current count, registered.
- wrap  output  1  Registered one-cycle pulse: count wrapped (SATURATE=0 only).
- sat_hit  output  1  Registered one-cycle pulse: count attempted beyond range and held (SATURATE=1 only).
- ovf_sticky  output  1  Sticky flag: set on any wrap or sat_hit event; cleared only by clear or reset.
- at_max  output  1  Combinational: q_out == MAX_VAL.
- at_zero  output  1  Combinational: q_out == 0.

Behaviour:
- Reset (reset_n low, asynchronous, any time including mid-count): q_out=0, wrap=0, sat_hit=0, ovf_sticky=0. First update occurs on the first rising clk after reset_n deasserts.
- Command priority each rising edge: clear > load > count_en > hold.
- clear=1:
  - q_out <= 0, ovf_sticky <= 0, wrap <= 0, sat_hit <= 0.
  - load and count_en are ignored that cycle.
- load=1 (clear=0):
  - q_out <= min(load_val, MAX_VAL).
  - wrap and sat_hit <= 0; ovf_sticky unchanged.
  - count_en is ignored that cycle.
- count_en=1, up_dn=1:
  - q_out < MAX_VAL: q_out <= q_out+1.
  - q_out == MAX_VAL, SATURATE=0: q_out <= 0, wrap <= 1.
  - q_out == MAX_VAL, SATURATE=1: q_out holds, sat_hit <= 1.
- count_en=1, up_dn=0:
  - q_out > 0: q_out <= q_out-1.
  - q_out == 0, SATURATE=0: q_out <= MAX_VAL, wrap <= 1.
  - q_out == 0, SATURATE=1: q_out holds, sat_hit <= 1.
- count_en=0, no command: q_out holds; wrap and sat_hit <= 0.
- wrap and sat_hit are high for exactly the one cycle after the causing edge. Back-to-back wrap events (e.g. MAX_VAL=1) produce consecutive high cycles.
- ovf_sticky <= 1 in the same edge as any wrap or sat_hit assertion; it remains set thereafter until clear or reset.
- Arithmetic:
  - Comparisons against MAX_VAL are done at WIDTH bits.
  - Increment/decrement never produces an intermediate value outside 0..MAX_VAL.
  - No reliance on natural 2**WIDTH rollover when MAX_VAL < 2**WIDTH-1.
- at_max and at_zero are decoded from registered q_out only; they carry no input-to-output combinational path.
- Direction change takes effect on the next edge with no dead cycle.
- Latency: one clock from command to q_out.

Test Plan (WIDTH=4, MAX_VAL=9 unless stated):
- Async reset: assert reset_n=0 mid-count at q_out=5, between clock edges.
  -> q_out=0, flags=0 immediately.
  -> First count after release gives q_out=1.
- Up-count wrap, SATURATE=0: count_en=1, up_dn=1 from 0 for 11 clocks.
  -> q_out goes 1..9, then 0, then 1.
  -> wrap high for exactly one cycle, coincident with q_out=0.
  -> ovf_sticky=1 from that cycle on.
- Down-count saturate, SATURATE=1: load 2, then count down for 4 clocks.
  -> q_out goes 1, 0, 0, 0.
  -> sat_hit high on the 3rd and 4th cycles.
  -> at_zero=1 while q_out=0.
- Load clamp and priority: load=1, load_val=14, count_en=1.
  -> q_out=9, at_max=1, no count that cycle.
  -> Then clear=1 with load=1 -> q_out=0, ovf_sticky=0.
- Direction toggle: from q_out=4, drive up_dn 1, 0, 1, 0 with count_en=1.
  -> q_out goes 5, 4, 5, 4; wrap stays 0.
- Full-range wrap (MAX_VAL=15): count up from 15.
  -> q_out=0, wrap=1.
  -> Count down from 0 -> q_out=15, wrap=1.
